// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction buffer boot loader.
// The header is four little-endian bytes: start address, then word count.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;

    localparam int HDR_BYTES = 4;

    function automatic int bytes_per_word(input int word_w, input int byte_w);
        return (word_w + byte_w - 1) / byte_w;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Collects BPW little-endian bytes into one buffer word.
// Bits of the final byte that fall beyond WORD_W are never stored.
module imem_byte_packer #(
    parameter int WORD_W = 46,
    parameter int BYTE_W = 8,
    parameter int BPW    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              word_full,
    output logic [WORD_W-1:0] packed_word
);

    localparam int CNT_W = $clog2(BPW + 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (shift_en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // High when the byte being accepted right now completes the word.
    assign word_full = shift_en && (cnt_reg == CNT_W'(BPW - 1));

    // Each word bit latches from its own byte lane when that lane's byte arrives.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
            logic bit_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bit_reg <= 1'b0;
                end else if (clear) begin
                    bit_reg <= 1'b0;
                end else if (shift_en && (cnt_reg == CNT_W'(gi / BYTE_W))) begin
                    bit_reg <= rx_byte[gi % BYTE_W];
                end
            end

            assign packed_word[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a host byte stream into header, instruction words and an
// XOR checksum, writes the instruction buffer, and releases the PAT core on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  I_ADR_WIDTH   = 10,
    parameter int  I_WIDTH       = 23,
    parameter int  I_BUFFER_SIZE = 2,
    parameter int  BYTE_W        = 8,
    localparam int WORD_W        = I_BUFFER_SIZE * I_WIDTH,
    localparam int BPW           = bytes_per_word(WORD_W, BYTE_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_req,
    input  logic                   abort,
    input  logic [BYTE_W-1:0]      rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [I_ADR_WIDTH-1:0] imem_write_adr,
    output logic                   imem_write,
    output logic [WORD_W-1:0]      imem_in,
    output logic                   pat_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int              HDR_W     = HDR_BYTES * BYTE_W;
    localparam int              HC_W      = $clog2(HDR_BYTES);
    localparam logic [16:0]     ADR_LIMIT = 17'(1) << I_ADR_WIDTH;

    state_t state_reg, state_next;

    logic [HC_W-1:0]         hdr_cnt_reg;
    logic [HDR_W-BYTE_W-1:0] hdr_reg;
    logic [I_ADR_WIDTH-1:0]  addr_reg;
    logic [15:0]             remaining_reg;
    logic [BYTE_W-1:0]       xor_reg;
    logic                    error_reg;
    logic                    pat_reset_reg;
    logic                    rx_ready_reg;

    logic              accept;
    logic              fail;
    logic              shift_en;
    logic              word_full;
    logic              packer_clear;
    logic [WORD_W-1:0] packed_word;
    logic [HDR_W-1:0]  hdr_full;
    logic [15:0]       hdr_sa;
    logic [15:0]       hdr_n;
    logic [16:0]       hdr_span;
    logic              hdr_last;
    logic              hdr_bad;

    // Abort wins over a byte offered in the same cycle.
    assign accept   = rx_valid && rx_ready_reg && !abort;
    assign shift_en = accept && (state_reg == DATA);

    // Header fields as they will look once the byte on rx_data is taken.
    assign hdr_full = {rx_data, hdr_reg};
    assign hdr_sa   = hdr_full[15:0];
    assign hdr_n    = hdr_full[31:16];
    assign hdr_span = {1'b0, hdr_sa} + {1'b0, hdr_n};
    assign hdr_last = (hdr_cnt_reg == HC_W'(HDR_BYTES - 1));
    assign hdr_bad  = ((hdr_sa >> I_ADR_WIDTH) != 16'd0) || (hdr_span > ADR_LIMIT);

    assign packer_clear = (state_next == DATA) && (state_reg != DATA);

    imem_byte_packer #(
        .WORD_W (WORD_W),
        .BYTE_W (BYTE_W),
        .BPW    (BPW)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (packer_clear),
        .shift_en    (shift_en),
        .rx_byte     (rx_data),
        .word_full   (word_full),
        .packed_word (packed_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fail       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_req) state_next = HDR;
            end
            HDR: begin
                if (accept && hdr_last) begin
                    if (hdr_bad) begin
                        state_next = IDLE;
                        fail       = 1'b1;
                    end else if (hdr_n == 16'd0) begin
                        state_next = CHK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) state_next = WRITE;
            end
            WRITE: begin
                state_next = (remaining_reg == 16'd1) ? CHK : DATA;
            end
            CHK: begin
                if (accept) begin
                    if (rx_data == xor_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = IDLE;
                        fail       = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if ((state_reg != IDLE) && abort) begin
            state_next = IDLE;
            fail       = 1'b1;
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        imem_write = 1'b0;
        imem_in    = '0;
        case (state_reg)
            HDR, DATA, CHK: busy = 1'b1;
            WRITE: begin
                busy       = 1'b1;
                imem_write = 1'b1;
                imem_in    = packed_word;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt_reg   <= '0;
            hdr_reg       <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            xor_reg       <= '0;
            error_reg     <= 1'b0;
            pat_reset_reg <= 1'b1;
            rx_ready_reg  <= 1'b0;
        end else begin
            rx_ready_reg <= (state_next == HDR) || (state_next == DATA) || (state_next == CHK);
            if ((state_reg == IDLE) && load_req) begin
                error_reg     <= 1'b0;
                pat_reset_reg <= 1'b1;
                hdr_cnt_reg   <= '0;
                xor_reg       <= '0;
            end
            if (accept && (state_reg == HDR)) begin
                hdr_cnt_reg <= hdr_cnt_reg + HC_W'(1);
                hdr_reg     <= hdr_full[HDR_W-1:BYTE_W];
                if (hdr_last) begin
                    addr_reg      <= hdr_sa[I_ADR_WIDTH-1:0];
                    remaining_reg <= hdr_n;
                end
            end
            if (shift_en) begin
                xor_reg <= xor_reg ^ rx_data;
            end
            if (state_reg == WRITE) begin
                addr_reg      <= addr_reg + I_ADR_WIDTH'(1);
                remaining_reg <= remaining_reg - 16'd1;
            end
            if (state_next == DONE) begin
                pat_reset_reg <= 1'b0;
            end
            if (fail) begin
                error_reg     <= 1'b1;
                pat_reset_reg <= 1'b1;
            end
        end
    end

    assign rx_ready       = rx_ready_reg;
    assign imem_write_adr = addr_reg;
    assign pat_reset      = pat_reset_reg;
    assign error          = error_reg;

endmodule
